// File: rtl/cordic_rotate.sv
// Pipelined rotation-mode CORDIC: rotates (x_i, y_i) by z_i, gain K ~ 1.6468.
// Define PHASE_ACC_EN to treat z_i as a frequency word integrated by a phase accumulator.
module cordic_rotate #(
    parameter int DATA_W = 12,
    parameter int ITER   = 12,
    parameter int GUARD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] y_i,
    input  logic signed [DATA_W-1:0] z_i,
    input  logic                     valid_i,
    input  logic                     acc_clr_i,
    output logic signed [DATA_W+1:0] x_o,
    output logic signed [DATA_W+1:0] y_o,
    output logic                     valid_o
);

    localparam int XW = DATA_W + 2 + GUARD;
    localparam int ZW = DATA_W + GUARD;

    typedef logic signed [XW-1:0]       xw_t;
    typedef logic signed [ZW-1:0]       zw_t;
    typedef logic signed [DATA_W+1:0]   xo_t;

    localparam zw_t Z_HALF_PI = zw_t'(1) <<< (ZW - 2);

    // atan(2^-i) in units where 2^31 == pi; rescaled with rounding to ZW bits below.
    function automatic logic [31:0] atan_t32(input int i);
        case (i)
            0:  atan_t32 = 32'd536870912;
            1:  atan_t32 = 32'd316933406;
            2:  atan_t32 = 32'd167458907;
            3:  atan_t32 = 32'd85004756;
            4:  atan_t32 = 32'd42667331;
            5:  atan_t32 = 32'd21354465;
            6:  atan_t32 = 32'd10679838;
            7:  atan_t32 = 32'd5340245;
            8:  atan_t32 = 32'd2670163;
            9:  atan_t32 = 32'd1335087;
            10: atan_t32 = 32'd667544;
            11: atan_t32 = 32'd333772;
            12: atan_t32 = 32'd166886;
            13: atan_t32 = 32'd83443;
            14: atan_t32 = 32'd41722;
            15: atan_t32 = 32'd20861;
            16: atan_t32 = 32'd10430;
            17: atan_t32 = 32'd5215;
            18: atan_t32 = 32'd2608;
            19: atan_t32 = 32'd1304;
            20: atan_t32 = 32'd652;
            21: atan_t32 = 32'd326;
            22: atan_t32 = 32'd163;
            23: atan_t32 = 32'd81;
            24: atan_t32 = 32'd41;
            25: atan_t32 = 32'd20;
            26: atan_t32 = 32'd10;
            27: atan_t32 = 32'd5;
            28: atan_t32 = 32'd3;
            29: atan_t32 = 32'd1;
            30: atan_t32 = 32'd1;
            default: atan_t32 = 32'd0;
        endcase
    endfunction

    function automatic zw_t atan_z(input int i);
        logic [32:0] t;
        t = {1'b0, atan_t32(i)} + (33'd1 << (31 - ZW));
        return zw_t'(t >> (32 - ZW));
    endfunction

    logic signed [DATA_W-1:0] src_x, src_y, src_z;
    logic                     src_v;

`ifdef PHASE_ACC_EN
    logic signed [DATA_W-1:0] xin_q, xin_d, yin_q, yin_d, acc_q, acc_d;
    logic                     vin_q, vin_d;

    // The sample arriving with acc_clr_i sees angle 0, not the old phase.
    always_comb begin
        xin_d = x_i;
        yin_d = y_i;
        vin_d = valid_i;
        acc_d = acc_q;
        if (acc_clr_i)
            acc_d = '0;
        else if (valid_i)
            acc_d = acc_q + z_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xin_q <= '0;
            yin_q <= '0;
            vin_q <= 1'b0;
            acc_q <= '0;
        end else begin
            xin_q <= xin_d;
            yin_q <= yin_d;
            vin_q <= vin_d;
            acc_q <= acc_d;
        end
    end

    assign src_x = xin_q;
    assign src_y = yin_q;
    assign src_z = acc_q;
    assign src_v = vin_q;
`else
    logic acc_clr_unused;
    assign acc_clr_unused = acc_clr_i;

    assign src_x = x_i;
    assign src_y = y_i;
    assign src_z = z_i;
    assign src_v = valid_i;
`endif

    // Index 0 is the pre-rotation register; index i+1 holds the result of micro-rotation i.
    // The final angle residual is never needed, so z stops one register short of x/y.
    xw_t              x_q [0:ITER];
    xw_t              x_d [0:ITER];
    xw_t              y_q [0:ITER];
    xw_t              y_d [0:ITER];
    zw_t              z_q [0:ITER-1];
    zw_t              z_d [0:ITER-1];
    logic [ITER+1:0]  vld_pipe_q, vld_pipe_d;
    xo_t              xo_q, xo_d, yo_q, yo_d;

    xw_t  x_ext, y_ext;
    zw_t  z_ext;
    logic pre_rot;

    always_comb begin
        xw_t xs, ys;

        x_ext = xw_t'(src_x) <<< GUARD;
        y_ext = xw_t'(src_y) <<< GUARD;
        z_ext = zw_t'(src_z) <<< GUARD;

        // Fold angles in (pi/2, pi] and [-pi, -pi/2) by a half turn; +pi/2 itself converges unfolded.
        pre_rot = (z_ext[ZW-1] != z_ext[ZW-2]) && (z_ext != Z_HALF_PI);
        x_d[0] = pre_rot ? -x_ext : x_ext;
        y_d[0] = pre_rot ? -y_ext : y_ext;
        z_d[0] = pre_rot ? {~z_ext[ZW-1], z_ext[ZW-2:0]} : z_ext;

        for (int i = 0; i < ITER; i++) begin
            xs = x_q[i] >>> i;
            ys = y_q[i] >>> i;
            if (!z_q[i][ZW-1]) begin
                x_d[i+1] = x_q[i] - ys;
                y_d[i+1] = y_q[i] + xs;
            end else begin
                x_d[i+1] = x_q[i] + ys;
                y_d[i+1] = y_q[i] - xs;
            end
        end

        for (int i = 1; i < ITER; i++) begin
            if (!z_q[i-1][ZW-1])
                z_d[i] = z_q[i-1] - atan_z(i - 1);
            else
                z_d[i] = z_q[i-1] + atan_z(i - 1);
        end

        xo_d       = xo_t'(x_q[ITER] >>> GUARD);
        yo_d       = xo_t'(y_q[ITER] >>> GUARD);
        vld_pipe_d = {vld_pipe_q[ITER:0], src_v};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= ITER; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            for (int i = 0; i < ITER; i++)
                z_q[i] <= '0;
            vld_pipe_q <= '0;
            xo_q       <= '0;
            yo_q       <= '0;
        end else begin
            for (int i = 0; i <= ITER; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            for (int i = 0; i < ITER; i++)
                z_q[i] <= z_d[i];
            vld_pipe_q <= vld_pipe_d;
            xo_q       <= xo_d;
            yo_q       <= yo_d;
        end
    end

    assign x_o     = xo_q;
    assign y_o     = yo_q;
    assign valid_o = vld_pipe_q[ITER+1];

endmodule

// File: doc/cordic_rotate.md
Name: cordic_rotate

Overview:
Pipelined CORDIC in rotation mode. It rotates the vector (x_i, y_i) by the angle z_i and emits the rotated vector (x_o, y_o); with x_i = A and y_i = 0 it acts as a phase-to-IQ generator (cos/sin). It is the inverse-direction companion of cordic_vector, which converts IQ to phase/frequency. With the optional phase accumulator it becomes an FM modulator whose input is the same frequency word that cordic_vector produces.

Parameters:
DATA_W, 12, width of x_i/y_i/z_i (signed two's complement).
ITER, 12, number of CORDIC micro-rotation stages (1..DATA_W+2).
GUARD, 2, extra internal LSBs on x/y/z datapaths.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
x_i  in  DATA_W  signed input vector real part
y_i  in  DATA_W  signed input vector imag part
z_i  in  DATA_W  signed angle; full-scale: 0x800 = -pi, 0x400 = +pi/2, 0x200 = +pi/4 (or frequency word under PHASE_ACC_EN)
valid_i  in  1  input sample valid
acc_clr_i  in  1  clears phase accumulator (ignored when PHASE_ACC_EN undefined)
x_o  out  DATA_W+2  signed rotated real part, scaled by CORDIC gain K~1.6468
y_o  out  DATA_W+2  signed rotated imag part, scaled by K
valid_o  out  1  output valid

Behaviour:
- Reset (async, rst=1): all pipeline x/y/z registers, valid shift chain, x_o, y_o, valid_o and phase accumulator -> 0 immediately. A reset mid-stream discards all in-flight samples; no valid_o until new inputs traverse the pipe.
- No backpressure. Accepts one sample per clock whenever valid_i=1. Data registers advance every cycle regardless of valid; only the valid chain qualifies them.
- Stage 0 (pre-rotation, registered): sign-extend x/y to DATA_W+2 bits plus GUARD LSBs; z to DATA_W+GUARD bits.
  - If z's top two bits are 01 or 10 (|angle| > pi/2): negate x and y, and flip z MSB (z += pi mod 2pi).
  - Otherwise pass through unchanged.
  - Exactly pi/2 (0x400) and -pi/2 (0xC00) are not pre-rotated.
- Stage i (i=0..ITER-1, registered): d = (z >= 0) ? +1 : -1.
  - x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*ATAN[i].
  - ATAN[i] = round(atan(2^-i) * 2^(DATA_W+GUARD-1)/pi), held as a constant table.
  - Shifts are arithmetic. z wraps modulo 2^(DATA_W+GUARD).
- Output: x_o/y_o = final x/y with GUARD LSBs dropped by truncation; no gain compensation and no saturation (DATA_W+2 bits covers K*sqrt(2)*2^(DATA_W-1)).
- Latency: ITER+1 clocks from valid_i high at a rising edge to valid_o high (13 with defaults). valid_o pattern exactly equals valid_i delayed ITER+1 cycles; gaps are preserved.
- Accuracy: |error| <= 3 LSB of x_o/y_o versus ideal K*rotation for all inputs with |x_i|,|y_i| <= 2^(DATA_W-1)-1.

Optional Feature:
PHASE_ACC_EN
- Defined: z_i is a signed frequency word. A DATA_W-bit register phase_acc updates on each valid_i: phase_acc <= phase_acc + z_i, wrapping modulo 2^DATA_W. The rotation angle fed to stage 0 is the updated value. acc_clr_i=1 sets phase_acc to 0 that cycle, with priority over valid_i; the sample presented with it uses angle 0. This adds one register stage, so latency = ITER+2.
- Undefined: z_i is used directly as the angle, acc_clr_i is ignored, and latency = ITER+1.

Test Plan:
- Cardinal angles: x_i=0x200, y_i=0. z_i=0x000 -> (x_o,y_o) ~ (843,0); z_i=0x400 -> (0,843); z_i=0xC00 -> (0,-843); z_i=0x800 -> (-843,0). Each within +/-3.
- Diagonal and pre-rotation boundary: x_i=0x200, y_i=0, z_i=0x200 -> ~(596,596); z_i=0x600 (3pi/4) -> ~(-596,596); z_i=0xA00 -> ~(-596,-596).
- Latency/streaming: 256 back-to-back valid samples then valid_i=0. First valid_o occurs exactly 13 clocks after the first valid_i; 256 consecutive valid_o follow, then 0. A 1-cycle valid_i gap in the input reproduces as a gap at the output.
- Full-scale input: x_i=0x7FF, y_i=0x7FF, z_i=0x200 -> x_o ~ 0, y_o ~ 4767. No overflow or wrap.
- Async reset mid-stream: assert rst between clock edges after 5 samples are in flight. x_o, y_o and valid_o go 0 immediately; after release, no valid_o appears until new inputs have been in the pipe 13 cycles.
- PHASE_ACC_EN: x_i=0x200, y_i=0, z_i=0x100 constant, valid_i=1. Successive outputs step by pi/8, returning to ~(843,0) every 16 samples. Pulsing acc_clr_i yields ~(843,0) at latency 14.
